// File: rtl/huffman_dec_controller.sv
// huffman_dec_controller
//   JPEG Huffman decode controller. Pulls an entropy-coded byte stream into a
//   left-aligned bit buffer. It presents the top 16 bits to an external
//   combinational lookup table. From the table's answer it rebuilds the
//   64-coefficient zigzag matrix of one 8x8 block.
//
//   Optional feature: define DC_PREDICT_EN to treat the decoded DC value as
//   a difference from the previous block's DC. This adds the pred_clear
//   input.
//
// Ports
//   clock, reset_n   system clock, synchronous active-low reset
//   dec_start        pulse: decode one block (ignored unless idle)
//   byte_in/valid    stream bytes, MSB first; byte_ready = accepted
//   peek_bits        top 16 buffer bits, to the lookup table
//   lookup_dc        1 = DC table, 0 = AC table
//   lut_length/run/size  table answer (length 0 = no match)
//   pred_clear       (DC_PREDICT_EN only) clear DC predictor while idle
//   zigzag_pix_out   coefficient k on bits [8k+7:8k]
//   block_valid      one-cycle pulse when the matrix is complete/abandoned
//   busy             decoding in progress
//   decode_error     sticky error flag, cleared by dec_start
module huffman_dec_controller #(
  parameter int unsigned MAX_SIZE = 8,
  parameter int unsigned BUF_W    = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         dec_start,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic [15:0]  peek_bits,
  output logic         lookup_dc,
  input  logic [4:0]   lut_length,
  input  logic [3:0]   lut_run,
  input  logic [3:0]   lut_size,
`ifdef DC_PREDICT_EN
  input  logic         pred_clear,
`endif
  output logic [511:0] zigzag_pix_out,
  output logic         block_valid,
  output logic         busy,
  output logic         decode_error
);

  localparam int unsigned CW       = $clog2(BUF_W + 1);
  localparam int unsigned STEP_MIN = 16 + MAX_SIZE;

  typedef enum logic [2:0] {S_IDLE, S_DC, S_AC, S_DONE, S_ERR} state_t;

  state_t             state_q, state_n;
  logic [BUF_W-1:0]   buf_q, buf_n;
  logic [CW-1:0]      cnt_q, cnt_n, cnt_after, shift_amt, consume;
  logic [6:0]         idx_q, idx_n, ac_pos, zrl_idx;
  logic [511:0]       coef_q;
  logic               err_q;
  logic [7:0]         pred_q;

  logic               step_ok, in_take, sym_bad;
  logic [MAX_SIZE-1:0] amp_field, amp_raw;
  logic [7:0]         amp8, mask8, value, dc_value;
  logic               wr_en, start_clr, set_err, pred_upd;
  logic [5:0]         wr_idx;
  logic [7:0]         wr_val;

  assign peek_bits      = buf_q[BUF_W-1 -: 16];
  assign lookup_dc      = (state_q == S_DC);
  assign busy           = (state_q == S_DC) || (state_q == S_AC);
  assign block_valid    = (state_q == S_DONE) || (state_q == S_ERR);
  assign decode_error   = err_q;
  assign zigzag_pix_out = coef_q;
  assign byte_ready     = (state_q != S_IDLE) && (cnt_q <= CW'(BUF_W - 8));
  assign in_take        = byte_valid && byte_ready;
  assign step_ok        = (cnt_q >= CW'(STEP_MIN));
  assign consume        = CW'(lut_length) + CW'(lut_size);
  assign sym_bad        = (lut_length == 5'd0) || (lut_length > 5'd16) ||
                          (32'(lut_size) > MAX_SIZE);

  // Amplitude bits start right after the matched code. The first of them is
  // the sign indicator. Negative values use the one's-complement style
  // offset a - (2^s - 1), evaluated modulo 256.
  always_comb begin
    amp_field = MAX_SIZE'(buf_q >> (BUF_W - MAX_SIZE - 32'(lut_length)));
    amp_raw   = amp_field >> (MAX_SIZE - 32'(lut_size));
    amp8      = 8'(amp_raw);
    mask8     = ~(8'hFF << lut_size);
    value     = amp_field[MAX_SIZE-1] ? amp8 : (amp8 - mask8);
    if (lut_size == 4'd0) value = 8'd0;
`ifdef DC_PREDICT_EN
    dc_value  = pred_q + value;
`else
    dc_value  = value;
`endif
  end

  assign ac_pos  = idx_q + 7'(lut_run);
  assign zrl_idx = idx_q + 7'd16;

  always_comb begin
    state_n   = state_q;
    shift_amt = '0;
    idx_n     = idx_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_val    = value;
    start_clr = 1'b0;
    set_err   = 1'b0;
    pred_upd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dec_start) begin
          start_clr = 1'b1;
          idx_n     = '0;
          state_n   = S_DC;
        end
      end
      S_DC: begin
        if (step_ok) begin
          if (sym_bad) begin
            set_err = 1'b1;
            state_n = S_ERR;
          end else begin
            shift_amt = consume;
            wr_en     = 1'b1;
            wr_val    = dc_value;
            pred_upd  = 1'b1;
            idx_n     = 7'd1;
            state_n   = S_AC;
          end
        end
      end
      S_AC: begin
        if (step_ok) begin
          if (sym_bad) begin
            set_err = 1'b1;
            state_n = S_ERR;
          end else if (lut_run == 4'd0 && lut_size == 4'd0) begin
            shift_amt = consume;
            state_n   = S_DONE;
          end else if (lut_run == 4'd15 && lut_size == 4'd0) begin
            if (zrl_idx > 7'd64) begin
              set_err = 1'b1;
              state_n = S_ERR;
            end else begin
              shift_amt = consume;
              idx_n     = zrl_idx;
              if (zrl_idx == 7'd64) state_n = S_DONE;
            end
          end else begin
            if (ac_pos > 7'd63) begin
              set_err = 1'b1;
              state_n = S_ERR;
            end else begin
              shift_amt = consume;
              wr_en     = 1'b1;
              wr_idx    = ac_pos[5:0];
              idx_n     = ac_pos + 7'd1;
              if (ac_pos == 7'd63) state_n = S_DONE;
            end
          end
        end
      end
      S_DONE, S_ERR: state_n = S_IDLE;
      default:       state_n = S_IDLE;
    endcase
  end

  // Consume first, then append the new byte directly below the remaining
  // bits. This keeps every bit under cnt zero.
  always_comb begin
    cnt_after = cnt_q - shift_amt;
    buf_n     = buf_q << shift_amt;
    cnt_n     = cnt_after;
    if (in_take) begin
      buf_n = buf_n | ((BUF_W'(byte_in) << (BUF_W - 8)) >> cnt_after);
      cnt_n = cnt_after + CW'(8);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      coef_q  <= '0;
      err_q   <= 1'b0;
      pred_q  <= '0;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      if (start_clr) begin
        coef_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if (wr_en) coef_q[{wr_idx, 3'b000} +: 8] <= wr_val;
        if (set_err) err_q <= 1'b1;
      end
`ifdef DC_PREDICT_EN
      if (state_q == S_IDLE && pred_clear) pred_q <= '0;
      else if (pred_upd)                   pred_q <= dc_value;
`else
      if (pred_upd) pred_q <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_huffman_dec_controller.sv
module tb_huffman_dec_controller;

  logic         clock = 1'b0;
  logic         reset_n, dec_start, byte_valid;
  logic [7:0]   byte_in;
  logic         byte_ready, lookup_dc, block_valid, busy, decode_error;
  logic [15:0]  peek_bits;
  logic [4:0]   lut_length;
  logic [3:0]   lut_run, lut_size;
  logic [511:0] zigzag_pix_out;
`ifdef DC_PREDICT_EN
  logic         pred_clear;
`endif

  always #5 clock = ~clock;

  huffman_dec_controller #(.MAX_SIZE(8), .BUF_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .dec_start(dec_start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .peek_bits(peek_bits), .lookup_dc(lookup_dc),
    .lut_length(lut_length), .lut_run(lut_run), .lut_size(lut_size),
`ifdef DC_PREDICT_EN
    .pred_clear(pred_clear),
`endif
    .zigzag_pix_out(zigzag_pix_out), .block_valid(block_valid),
    .busy(busy), .decode_error(decode_error)
  );

  // External lookup table: {length, run, size}
  function automatic logic [12:0] lut(input logic [15:0] p, input logic dc);
    logic [12:0] r;
    r = '0;
    if (dc) begin
      casez (p[15:9])
        7'b00?????: r = {5'd2, 4'd0, 4'd0};
        7'b010????: r = {5'd3, 4'd0, 4'd3};
        7'b011????: r = {5'd3, 4'd0, 4'd1};
        7'b100????: r = {5'd3, 4'd0, 4'd2};
        7'b101????: r = {5'd3, 4'd0, 4'd4};
        7'b110????: r = {5'd3, 4'd0, 4'd5};
        7'b1110???: r = {5'd4, 4'd0, 4'd6};
        7'b11110??: r = {5'd5, 4'd0, 4'd7};
        7'b111110?: r = {5'd6, 4'd0, 4'd8};
        7'b1111110: r = {5'd7, 4'd0, 4'd9};
        default:    r = '0;
      endcase
    end else begin
      casez (p[15:10])
        6'b00????: r = {5'd2, 4'd0, 4'd1};
        6'b01????: r = {5'd2, 4'd0, 4'd2};
        6'b100???: r = {5'd3, 4'd0, 4'd3};
        6'b1010??: r = {5'd4, 4'd0, 4'd0};
        6'b1011??: r = {5'd4, 4'd1, 4'd1};
        6'b1100??: r = {5'd4, 4'd2, 4'd1};
        6'b11010?: r = {5'd5, 4'd15, 4'd0};
        6'b11011?: r = {5'd5, 4'd15, 4'd1};
        6'b11100?: r = {5'd5, 4'd0, 4'd8};
        6'b11101?: r = {5'd5, 4'd3, 4'd4};
        6'b111100: r = {5'd6, 4'd1, 4'd3};
        6'b111101: r = {5'd6, 4'd0, 4'd9};
        default:   r = '0;
      endcase
    end
    return r;
  endfunction

  always_comb {lut_length, lut_run, lut_size} = lut(peek_bits, lookup_dc);

  // Encoder view of the same table: {len, code}. size 15 = a no-match code.
  function automatic logic [11:0] code_of(input logic dc, input logic [3:0] run,
                                          input logic [3:0] size);
    case ({dc, run, size})
      9'h100: return {4'd2, 8'b00};
      9'h103: return {4'd3, 8'b010};
      9'h101: return {4'd3, 8'b011};
      9'h102: return {4'd3, 8'b100};
      9'h104: return {4'd3, 8'b101};
      9'h105: return {4'd3, 8'b110};
      9'h106: return {4'd4, 8'b1110};
      9'h107: return {4'd5, 8'b11110};
      9'h108: return {4'd6, 8'b111110};
      9'h109: return {4'd7, 8'b1111110};
      9'h10F: return {4'd7, 8'b1111111};
      9'h001: return {4'd2, 8'b00};
      9'h002: return {4'd2, 8'b01};
      9'h003: return {4'd3, 8'b100};
      9'h000: return {4'd4, 8'b1010};
      9'h011: return {4'd4, 8'b1011};
      9'h021: return {4'd4, 8'b1100};
      9'h0F0: return {4'd5, 8'b11010};
      9'h0F1: return {4'd5, 8'b11011};
      9'h008: return {4'd5, 8'b11100};
      9'h034: return {4'd5, 8'b11101};
      9'h013: return {4'd6, 8'b111100};
      9'h009: return {4'd6, 8'b111101};
      9'h00F: return {4'd5, 8'b11111};
      default: return '0;
    endcase
  endfunction

  typedef struct {
    logic [511:0] coefs;
    bit           err;
    bit           clr;
  } exp_t;

  exp_t         sb[$];
  exp_t         seg_q[$];
  bit           bq[$];
  logic [7:0]   bytes[$];
  logic [511:0] m_exp;
  bit           m_err, m_clr;
  int           m_k;
  logic [7:0]   m_pred;
  bit           took;
  int unsigned  n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic put_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  task automatic put_code(input logic dc, input int run, input int size);
    logic [11:0] c;
    c = code_of(dc, 4'(run), 4'(size));
    put_bits(32'(c[7:0]), int'(c[11:8]));
  endtask

  task automatic put_amp(input int v, input int s);
    if (s > 0) put_bits((v > 0) ? v : v + (1 << s) - 1, s);
  endtask

  function automatic int rnd_val(input int s);
    int mag;
    if (s == 0) return 0;
    mag = int'($urandom_range((1 << s) - 1, 1 << (s - 1)));
    return ($urandom_range(1) == 1) ? mag : -mag;
  endfunction

  task automatic begin_block();
    m_exp = '0;
    m_err = 1'b0;
    m_k   = 0;
    m_clr = 1'b0;
`ifdef DC_PREDICT_EN
    m_clr = ($urandom_range(3) == 0);
    if (m_clr) m_pred = '0;
`endif
  endtask

  task automatic end_block();
    exp_t e;
    e.coefs = m_exp;
    e.err   = m_err;
    e.clr   = m_clr;
    seg_q.push_back(e);
  endtask

  task automatic sym_dc(input int s, input int v);
    logic [7:0] c;
    put_code(1'b1, 0, s);
    put_amp(v, s);
    c = 8'(v);
`ifdef DC_PREDICT_EN
    c = m_pred + c;
    m_pred = c;
`endif
    m_exp[7:0] = c;
    m_k = 1;
  endtask

  task automatic sym_ac(input int run, input int size, input int v);
    put_code(1'b0, run, size);
    put_amp(v, size);
    if (run == 0 && size == 0) return;
    if (run == 15 && size == 0) begin
      m_k += 16;
      return;
    end
    m_k += run;
    m_exp[8*m_k +: 8] = 8'(v);
    m_k++;
  endtask

  task automatic gen_random_block();
    int sel, run, size, s;
    begin_block();
    s = int'($urandom_range(8));
    sym_dc(s, rnd_val(s));
    while (m_k < 64) begin
      sel = int'($urandom_range(10));
      if (sel == 0) begin
        sym_ac(0, 0, 0);
        break;
      end else if (sel == 1) begin
        if (m_k + 16 <= 64) sym_ac(15, 0, 0);
      end else begin
        case (sel)
          2: begin run = 0;  size = 1; end
          3: begin run = 0;  size = 2; end
          4: begin run = 0;  size = 3; end
          5: begin run = 1;  size = 1; end
          6: begin run = 2;  size = 1; end
          7: begin run = 15; size = 1; end
          8: begin run = 0;  size = 8; end
          9: begin run = 3;  size = 4; end
          default: begin run = 1; size = 3; end
        endcase
        if (m_k + run <= 63) sym_ac(run, size, rnd_val(size));
      end
    end
    end_block();
  endtask

  // Error blocks: nothing is consumed by the failing symbol, so its bits
  // are only emitted to steer the table.
  task automatic gen_err_block(input int kind);
    int s;
    begin_block();
    if (kind == 0) put_code(1'b1, 0, 15);
    else if (kind == 1) put_code(1'b1, 0, 9);
    else begin
      s = int'($urandom_range(8));
      sym_dc(s, rnd_val(s));
      if (kind == 2 || kind == 3) begin
        repeat ($urandom_range(3)) sym_ac(0, 1, rnd_val(1));
        put_code(1'b0, 0, (kind == 2) ? 15 : 9);
      end else begin
        repeat (3) sym_ac(15, 0, 0);
        if (kind == 4) put_code(1'b0, 15, 0);
        else           put_code(1'b0, 15, 1);
      end
    end
    m_err = 1'b1;
    end_block();
  endtask

  task automatic pack_stream();
    logic [7:0] b;
    while (bq.size() % 8 != 0) bq.push_back(1'b0);
    repeat (32) bq.push_back(1'b0);
    while (bq.size() > 0) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bq.pop_front()};
      bytes.push_back(b);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    dec_start = 1'b0;
`ifdef DC_PREDICT_EN
    pred_clear = 1'b0;
`endif
    if (byte_valid && took && bytes.size() > 0) void'(bytes.pop_front());
    if (bytes.size() > 0 && $urandom_range(3) != 0) begin
      byte_valid = 1'b1;
      byte_in    = bytes[0];
    end else begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
    end
    #1 took = byte_ready;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_block_valid"}, 512'(block_valid), '0);
    chk({tag, "_busy"}, 512'(busy), '0);
    chk({tag, "_decode_error"}, 512'(decode_error), '0);
    chk({tag, "_byte_ready"}, 512'(byte_ready), '0);
    chk({tag, "_lookup_dc"}, 512'(lookup_dc), '0);
    chk({tag, "_peek_bits"}, 512'(peek_bits), '0);
    chk({tag, "_zigzag"}, zigzag_pix_out, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bytes.delete();
    bq.delete();
    seg_q.delete();
    byte_valid = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    sb.delete();
    m_pred = '0;
    reset_n = 1'b1;
  endtask

  task automatic run_segment();
    exp_t e;
    int   cyc;
    pack_stream();
    while (seg_q.size() > 0) begin
      e = seg_q.pop_front();
      tick();
      dec_start = 1'b1;
`ifdef DC_PREDICT_EN
      pred_clear = e.clr;
`endif
      sb.push_back(e);
      cyc = 0;
      while (sb.size() > 0 && cyc < 3000) begin
        tick();
        if (busy && $urandom_range(7) == 0) dec_start = 1'b1;
        cyc++;
      end
      if (sb.size() > 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL block_timeout: got no block_valid after %0d cycles, want one", cyc);
        sb.delete();
      end
      tick();
      tick();
      chk("held_zigzag", zigzag_pix_out, e.coefs);
      chk("held_error", 512'(decode_error), 512'(e.err));
      chk("idle_busy", 512'(busy), '0);
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && block_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_block_valid: got 1 want 0");
        end else begin
          e = sb.pop_front();
          chk("block_zigzag", zigzag_pix_out, e.coefs);
          chk("block_error", 512'(decode_error), 512'(e.err));
          chk("block_busy", 512'(busy), '0);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    dec_start  = 1'b0;
    byte_valid = 1'b0;
    byte_in    = '0;
    took       = 1'b0;
`ifdef DC_PREDICT_EN
    pred_clear = 1'b0;
`endif
    do_reset();

    // Directed blocks
    begin_block(); sym_dc(3, 5);  sym_ac(0, 0, 0); end_block();
    begin_block(); sym_dc(2, -2); sym_ac(0, 0, 0); end_block();
    begin_block(); sym_dc(3, -5); sym_ac(0, 0, 0); end_block();
    begin_block(); sym_dc(0, 0);  sym_ac(2, 1, -1); sym_ac(0, 0, 0); end_block();
    begin_block(); sym_dc(8, -200);
    repeat (3) sym_ac(15, 0, 0);
    repeat (3) sym_ac(3, 4, rnd_val(4));
    sym_ac(1, 1, 1); sym_ac(0, 1, -1);
    end_block();
    run_segment();

    // Random multi-block segments, leftover bits carried between blocks
    repeat (6) begin
      do_reset();
      repeat ($urandom_range(5, 1)) gen_random_block();
      run_segment();
    end

    // Error blocks, each followed by a resynchronising reset
    for (int k = 0; k < 12; k++) begin
      do_reset();
      gen_err_block(k % 6);
      run_segment();
    end

    // Reset in the middle of a block
    do_reset();
    gen_random_block();
    pack_stream();
    seg_q.delete();
    tick();
    dec_start = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    check_zero_outputs("midreset");
    bytes.delete();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("post_midreset_busy", 512'(busy), '0);
    chk("post_midreset_zigzag", zigzag_pix_out, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
